sram_read_sense: RTL and testbench
==================================

SRAM_READ_SENSE -- requirements
Module: sram_read_sense

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bitline pairs (data bits) per row.
REQ-002 The block SHALL have parameter ROWS, default 16, meaning number of wordlines.
REQ-003 The block SHALL have parameter T_PRE, default 2, meaning precharge cycles (legal range 1..15).
REQ-004 The block SHALL have parameter T_DEV, default 3, meaning bitline develop cycles (legal range 1..15).
REQ-005 The block SHALL have parameter VDIFF, default 0.2 (real, volts), meaning minimum bitline differential for a valid read.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single clock; all flops use its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-008 The block SHALL have port rd_req, input, 1 bit, meaning read request.
REQ-009 The block SHALL have port rd_addr, input, $clog2(ROWS) bits, meaning row to read.
REQ-010 The block SHALL have port bl, input, real[WIDTH], meaning true bitline voltages (0.0..1.5 V).
REQ-011 The block SHALL have port blb, input, real[WIDTH], meaning complement bitline voltages.
REQ-012 The block SHALL have port rd_ready, output, 1 bit, meaning idle and able to accept.
REQ-013 The block SHALL have port pre, output, 1 bit, meaning bitline precharge enable.
REQ-014 The block SHALL have port wl, output, ROWS bits, meaning one-hot wordline drive.
REQ-015 The block SHALL have port sae, output, 1 bit, meaning sense-amp enable.
REQ-016 The block SHALL have port rd_data, output, WIDTH bits, meaning sensed data.
REQ-017 The block SHALL have port rd_err, output, WIDTH bits, meaning per-bit insufficient differential.
REQ-018 The block SHALL have port rd_valid, output, 1 bit, meaning one-cycle pulse qualifying rd_data and rd_err.

Function
REQ-019 The FSM SHALL have the states IDLE, PRECH, DEVELOP, SENSE and DONE; all outputs SHALL be registered.
REQ-020 In IDLE, rd_ready SHALL be 1 and the block SHALL be in no other state.
REQ-021 When rd_req=1 and rd_ready=1 on a rising edge, the block SHALL capture rd_addr and go to PRECH.
REQ-022 The block SHALL ignore rd_req while rd_ready=0; requests SHALL NOT be queued.
REQ-023 In PRECH, pre SHALL be 1 for exactly T_PRE cycles, then the block SHALL go to DEVELOP.
REQ-024 In DEVELOP, wl[captured addr] SHALL be 1 for T_DEV cycles and all other wl bits SHALL be 0; the block SHALL then go to SENSE.
REQ-025 In SENSE, wl SHALL stay on and sae SHALL be 1 for exactly 1 cycle.
REQ-026 At the end of SENSE, the block SHALL latch each bit i as follows:
- bl[i]-blb[i] >= VDIFF: rd_data[i]=1, rd_err[i]=0.
- blb[i]-bl[i] >= VDIFF: rd_data[i]=0, rd_err[i]=0.
- otherwise: rd_data[i]=0, rd_err[i]=1.
REQ-027 In DONE, rd_valid SHALL be 1 for exactly one cycle, wl SHALL be all 0, and the block SHALL then return to IDLE.
REQ-028 Latency: rd_valid SHALL assert T_PRE+T_DEV+2 cycles after the accepting edge (7 cycles at defaults).
REQ-029 pre and any wl bit SHALL never be 1 in the same cycle.
REQ-030 At most one wl bit SHALL be 1 at any time.
REQ-031 sae SHALL be 1 only in SENSE.
REQ-032 rd_data and rd_err SHALL hold their values until the next SENSE latch.
REQ-033 An out-of-range captured address (>= ROWS, non-power-of-2 ROWS) SHALL drive no wordline, and all bits SHALL report rd_err=1.
REQ-034 Changes to bl and blb outside the SENSE latch edge SHALL have no effect on the outputs.
REQ-035 Back-to-back reads: rd_req held high SHALL be accepted on the IDLE cycle following DONE, giving a minimum period of T_PRE+T_DEV+3 cycles.

Reset
REQ-036 While rst_n=0, the block SHALL immediately go to IDLE with rd_ready=1, pre=0, wl=0, sae=0, rd_valid=0, rd_data=0 and rd_err=0.
REQ-037 Reset asserted mid-operation (any state) SHALL abort the read with no rd_valid pulse and wl dropping at once.
REQ-038 The first request after reset deassertion SHALL be accepted on the first rising edge with rd_req=1.

Verification
REQ-039 Read a 1: addr=3, bl=1.5, blb=0.9 for all bits -> pre high 2 cycles, wl[3] high 4 cycles, rd_valid at cycle 7, rd_data=8'hFF, rd_err=0.
REQ-040 Mixed pattern: bl/blb set so that bits 0,2,4,6 have +0.5 V and the other bits -0.5 V -> rd_data=8'h55, rd_err=8'h00.
REQ-041 Weak differential: bit 5 has bl=1.2, blb=1.1 -> rd_data[5]=0, rd_err=8'h20.
REQ-042 rd_req pulsed during DEVELOP -> ignored; exactly one rd_valid, and rd_ready=1 returns the cycle after DONE.
REQ-043 rst_n low during DEVELOP of addr=9 -> wl=0 immediately, no rd_valid, state IDLE, rd_data=0.
REQ-044 Continuous rd_req alternating addr 0/15 -> rd_valid every 8 cycles; pre/wl overlap never occurs and wl is always one-hot or zero.

Source files
------------

// File: rtl/sram_read_sense.sv
// Read-path sequencer for one SRAM column group: precharge, wordline develop,
// sense-amp strobe and per-bit differential decision with registered outputs.
module sram_read_sense #(
    parameter int  WIDTH = 8,
    parameter int  ROWS  = 16,
    parameter int  T_PRE = 2,
    parameter int  T_DEV = 3,
    parameter real VDIFF = 0.2,
    localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr,
    input  real              bl  [WIDTH],
    input  real              blb [WIDTH],
    output logic             rd_ready,
    output logic             pre,
    output logic [ROWS-1:0]  wl,
    output logic             sae,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_err,
    output logic             rd_valid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRECH   = 3'd1,
        DEVELOP = 3'd2,
        SENSE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Counters load with (cycles - 1) and the phase ends when they reach zero.
    localparam logic [3:0] PRE_LOAD = 4'(T_PRE - 1);
    localparam logic [3:0] DEV_LOAD = 4'(T_DEV - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [AW-1:0]     addr_q;
    logic              rd_ready_q;
    logic              pre_q;
    logic [ROWS-1:0]   wl_q;
    logic              sae_q;
    logic              rd_valid_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic [WIDTH-1:0]  rd_err_q;

    logic [ROWS-1:0]   wl_dec;
    logic              addr_ok;
    logic [WIDTH-1:0]  sense_one;
    logic [WIDTH-1:0]  sense_zero;
    logic [WIDTH-1:0]  rd_data_d;
    logic [WIDTH-1:0]  rd_err_d;

    // Rows past ROWS (non-power-of-2 arrays) decode to no wordline at all.
    assign addr_ok = ({{(32-AW){1'b0}}, addr_q} < 32'(ROWS));

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_wl_dec
        assign wl_dec[gi] = (addr_q == AW'(gi));
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sense
        assign sense_one[gi]  = (bl[gi] - blb[gi]) >= VDIFF;
        assign sense_zero[gi] = (blb[gi] - bl[gi]) >= VDIFF;
        assign rd_data_d[gi]  = addr_ok & sense_one[gi];
        assign rd_err_d[gi]   = ~addr_ok | ~(sense_one[gi] | sense_zero[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rd_ready_q <= 1'b1;
            pre_q      <= 1'b0;
            wl_q       <= '0;
            sae_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        state_q    <= PRECH;
                        addr_q     <= rd_addr;
                        cnt_q      <= PRE_LOAD;
                        rd_ready_q <= 1'b0;
                        pre_q      <= 1'b1;
                    end
                end
                PRECH: begin
                    if (cnt_q == 4'd0) begin
                        // Precharge drops on the same edge the wordline rises.
                        state_q <= DEVELOP;
                        cnt_q   <= DEV_LOAD;
                        pre_q   <= 1'b0;
                        wl_q    <= wl_dec;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DEVELOP: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= SENSE;
                        sae_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SENSE: begin
                    state_q    <= DONE;
                    sae_q      <= 1'b0;
                    wl_q       <= '0;
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= rd_data_d;
                    rd_err_q   <= rd_err_d;
                end
                DONE: begin
                    state_q    <= IDLE;
                    rd_valid_q <= 1'b0;
                    rd_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    rd_ready_q <= 1'b1;
                    pre_q      <= 1'b0;
                    wl_q       <= '0;
                    sae_q      <= 1'b0;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_ready = rd_ready_q;
    assign pre      = pre_q;
    assign wl       = wl_q;
    assign sae      = sae_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_sram_read_sense.sv
// Directed bench for sram_read_sense: table of reads plus hand-written
// sequences for held inputs, ignored requests, mid-read reset and streaming.
module tb_sram_read_sense;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic [3:0]  rd_addr;
    real         bl  [8];
    real         blb [8];
    logic        rd_ready;
    logic        pre;
    logic [15:0] wl;
    logic        sae;
    logic [7:0]  rd_data;
    logic [7:0]  rd_err;
    logic        rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    sram_read_sense #(
        .WIDTH(8), .ROWS(16), .T_PRE(2), .T_DEV(3), .VDIFF(0.2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .bl(bl), .blb(blb), .rd_ready(rd_ready), .pre(pre), .wl(wl),
        .sae(sae), .rd_data(rd_data), .rd_err(rd_err), .rd_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-bit code: 0 strong zero, 1 strong one, 2 weak (0.1 V), 3 just over threshold (0.21 V).
    task automatic apply_codes(input logic [15:0] codes);
        for (int i = 0; i < 8; i++) begin
            case (codes[2*i +: 2])
                2'd0:    begin bl[i] = 0.9;  blb[i] = 1.4; end
                2'd1:    begin bl[i] = 1.5;  blb[i] = 0.9; end
                2'd2:    begin bl[i] = 1.2;  blb[i] = 1.1; end
                default: begin bl[i] = 1.21; blb[i] = 1.0; end
            endcase
        end
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] codes;
        logic [7:0]  exp_data;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs [6];

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("pre_wl_overlap", 32'(pre && (wl != 16'h0)), 32'd0);
            check("wl_onehot", 32'($countones(wl) <= 1), 32'd1);
            check("sae_without_wl", 32'(sae && (wl == 16'h0)), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Starts at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic do_read(input int idx, input vec_t v);
        int pre_n, wl_n, sae_at, valid_at;
        logic [15:0] exp_wl;
        exp_wl = 16'h1 << v.addr;
        pre_n = 0; wl_n = 0; sae_at = 0; valid_at = 0;
        apply_codes(v.codes);
        rd_addr = v.addr;
        rd_req  = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (pre) pre_n++;
            if (wl == exp_wl) wl_n++;
            else if (wl != 16'h0) wl_n += 100;
            if (sae && sae_at == 0) sae_at = c;
            if (rd_valid && valid_at == 0) valid_at = c;
            if (c == 8) check($sformatf("v%0d_ready_after_done", idx), 32'(rd_ready), 32'd1);
        end
        check($sformatf("v%0d_pre_cycles", idx), pre_n, 2);
        check($sformatf("v%0d_wl_cycles", idx), wl_n, 4);
        check($sformatf("v%0d_sae_cycle", idx), sae_at, 6);
        check($sformatf("v%0d_valid_cycle", idx), valid_at, 7);
        check($sformatf("v%0d_rd_data", idx), 32'(rd_data), 32'(v.exp_data));
        check($sformatf("v%0d_rd_err", idx), 32'(rd_err), 32'(v.exp_err));
        $display("read %0d addr=%0d data=%h err=%h valid_cycle=%0d", idx, v.addr, rd_data, rd_err, valid_at);
    endtask

    initial begin
        int vcnt, bad_wl, ready_n, last_v, gaps_ok;
        vecs[0] = '{4'd3,  16'h5555, 8'hFF, 8'h00};
        vecs[1] = '{4'd7,  16'h1111, 8'h55, 8'h00};
        vecs[2] = '{4'd12, 16'h5955, 8'hDF, 8'h20};
        vecs[3] = '{4'd0,  16'h0000, 8'h00, 8'h00};
        vecs[4] = '{4'd15, 16'hAAAA, 8'h00, 8'hFF};
        vecs[5] = '{4'd5,  16'h00FF, 8'h0F, 8'h00};

        rst_n = 1'b1; rd_req = 1'b0; rd_addr = 4'd0;
        apply_codes(16'h0000);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rd_ready", 32'(rd_ready), 32'd1);
        check("rst_pre", 32'(pre), 32'd0);
        check("rst_wl", 32'(wl), 32'd0);
        check("rst_sae", 32'(sae), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        rst_n = 1'b1;

        // The first read starts on the very first edge after reset release.
        for (int i = 0; i < 6; i++) do_read(i, vecs[i]);

        // Bitlines wrong until the sense cycle, garbage right after: only the latch edge counts.
        apply_codes(16'h0000);
        rd_addr = 4'd6; rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) check("hold_prev_data", 32'(rd_data), 32'h0F);
            if (c == 6) apply_codes(16'h5555);
            if (c == 7) begin
                check("latch_edge_valid", 32'(rd_valid), 32'd1);
                apply_codes(16'hAAAA);
            end
        end
        check("latch_edge_data", 32'(rd_data), 32'hFF);
        check("latch_edge_err", 32'(rd_err), 32'h00);
        $display("read latch-edge addr=6 data=%h err=%h", rd_data, rd_err);

        // Request pulsed while busy is dropped, not queued.
        apply_codes(16'h1111);
        rd_addr = 4'd2; rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        vcnt = 0; bad_wl = 0; ready_n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 3) begin rd_req = 1'b1; rd_addr = 4'd9; end
            if (c == 4) rd_req = 1'b0;
            if (rd_valid) vcnt++;
            if (wl != 16'h0 && wl != 16'h0004) bad_wl++;
            if (c >= 8 && rd_ready) ready_n++;
            if (c == 8) check("busy_req_ready_after_done", 32'(rd_ready), 32'd1);
        end
        check("busy_req_valid_count", vcnt, 1);
        check("busy_req_wrong_wl", bad_wl, 0);
        check("busy_req_stays_idle", ready_n, 13);
        check("busy_req_data", 32'(rd_data), 32'h55);
        $display("read busy-pulse addr=2 valids=%0d data=%h", vcnt, rd_data);

        // Reset in the middle of the develop phase.
        apply_codes(16'h5555);
        rd_addr = 4'd9; rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_wl_before", 32'(wl), 32'h0200);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wl_drop", 32'(wl), 32'd0);
        check("abort_ready", 32'(rd_ready), 32'd1);
        check("abort_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (rd_valid) vcnt++;
        end
        check("abort_no_valid", vcnt, 0);
        check("abort_idle", 32'(rd_ready), 32'd1);
        check("abort_err", 32'(rd_err), 32'd0);
        $display("read aborted addr=9 valids=%0d data=%h", vcnt, rd_data);

        // Streaming: rd_req held high, address alternating 0/15.
        apply_codes(16'h5555);
        rd_addr = 4'd0; rd_req = 1'b1;
        vcnt = 0; bad_wl = 0; last_v = 0; gaps_ok = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (wl != 16'h0 && wl != (16'h1 << rd_addr)) bad_wl++;
            if (rd_valid) begin
                vcnt++;
                if (vcnt == 1) check("stream_first_valid", c, 7);
                else if (c - last_v == 8) gaps_ok++;
                last_v = c;
                check("stream_data", 32'(rd_data), 32'hFF);
                $display("read stream addr=%0d data=%h cycle=%0d", rd_addr, rd_data, c);
                rd_addr = (rd_addr == 4'd0) ? 4'd15 : 4'd0;
            end
            if (c == 39) rd_req = 1'b0;
        end
        check("stream_valid_count", vcnt, 5);
        check("stream_period_8", gaps_ok, 4);
        check("stream_wl_addr", bad_wl, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
